// File: rtl/networkadapter_conf_arbiter_if.sv
// Bus bundle between NR_MASTERS requesting masters, the arbiter and the single
// configuration register slave.
interface networkadapter_conf_arbiter_if #(
    parameter int NR_MASTERS = 4,
    parameter int DW         = 32,
    parameter int AW         = 16
);
    // Handshake: master i requests with m_cyc[i] & m_stb[i] and holds the request
    // until it sees a one-cycle pulse on exactly one of m_ack[i], m_err[i] or
    // m_rty[i]; dropping m_cyc[i] while granted abandons the access with no pulse.
    // The slave answers combinationally on s_ack/s_err/s_rty while s_adr is valid.
    logic [NR_MASTERS-1:0]    m_cyc;
    logic [NR_MASTERS-1:0]    m_stb;
    logic [NR_MASTERS-1:0]    m_we;
    logic [NR_MASTERS*AW-1:0] m_adr;
    logic [NR_MASTERS*DW-1:0] m_dat_w;
    logic [DW-1:0]            m_dat_r;
    logic [NR_MASTERS-1:0]    m_ack;
    logic [NR_MASTERS-1:0]    m_err;
    logic [NR_MASTERS-1:0]    m_rty;

    logic [AW-1:0]            s_adr;
    logic                     s_we;
    logic [DW-1:0]            s_dat_w;
    logic [DW-1:0]            s_dat_r;
    logic                     s_ack;
    logic                     s_err;
    logic                     s_rty;

    logic [NR_MASTERS-1:0]    grant;
    logic [1:0]               dbg_state;

    // The arbiter is the slave of the masters and drives the slave-side bus.
    modport slave (
        input  m_cyc, m_stb, m_we, m_adr, m_dat_w,
        input  s_dat_r, s_ack, s_err, s_rty,
        output m_dat_r, m_ack, m_err, m_rty,
        output s_adr, s_we, s_dat_w,
        output grant, dbg_state
    );

    // Environment view: the masters plus the configuration register slave.
    modport master (
        output m_cyc, m_stb, m_we, m_adr, m_dat_w,
        output s_dat_r, s_ack, s_err, s_rty,
        input  m_dat_r, m_ack, m_err, m_rty,
        input  s_adr, s_we, s_dat_w,
        input  grant, dbg_state
    );
endinterface

// File: rtl/networkadapter_conf_arbiter.sv
// Round-robin arbiter sharing one configuration register slave among
// NR_MASTERS bus masters, one transaction in flight, with an access timeout.
module networkadapter_conf_arbiter #(
    parameter int NR_MASTERS = 4,
    parameter int DW         = 32,
    parameter int AW         = 16,
    parameter int TIMEOUT    = 15
) (
    input  logic clk,
    input  logic rst,
    networkadapter_conf_arbiter_if.slave bus
);
    localparam int IW = $clog2(NR_MASTERS);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [NR_MASTERS-1:0] grant_q, grant_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [IW-1:0]         ptr_q, ptr_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic                  rty_q, rty_d;
    logic [DW-1:0]         dat_r_q, dat_r_d;

    logic [NR_MASTERS-1:0] req;
    logic                  req_any;
    logic [IW-1:0]         win_idx;
    logic [IW-1:0]         win_next;
    logic [AW-1:0]         sel_adr;
    logic [DW-1:0]         sel_dat;
    logic                  sel_we;
    logic                  sel_cyc;
    logic                  s_any;

    // Round-robin search: scanning offsets from high to low leaves the
    // candidate closest to ptr (wrapping past NR_MASTERS-1) as the winner.
    always_comb begin
        int cand;
        logic [IW-1:0] cand_idx;
        req     = bus.m_cyc & bus.m_stb;
        req_any = 1'b0;
        win_idx = '0;
        cand    = 0;
        cand_idx = '0;
        for (int k = NR_MASTERS - 1; k >= 0; k--) begin
            cand = int'(ptr_q) + k;
            if (cand >= NR_MASTERS) begin
                cand = cand - NR_MASTERS;
            end
            cand_idx = IW'(cand);
            if (req[cand_idx]) begin
                req_any = 1'b1;
                win_idx = cand_idx;
            end
        end
        win_next = (win_idx == IW'(NR_MASTERS - 1)) ? '0 : win_idx + 1'b1;
    end

    always_comb begin
        sel_adr = bus.m_adr[int'(idx_q)*AW +: AW];
        sel_dat = bus.m_dat_w[int'(idx_q)*DW +: DW];
        sel_we  = bus.m_we[idx_q];
        sel_cyc = bus.m_cyc[idx_q];
        s_any   = bus.s_ack | bus.s_err | bus.s_rty;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            tmo_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rty_q   <= 1'b0;
            dat_r_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            tmo_q   <= tmo_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rty_q   <= rty_d;
            dat_r_q <= dat_r_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        tmo_d   = tmo_q;
        ack_d   = ack_q;
        err_d   = err_q;
        rty_d   = rty_q;
        dat_r_d = dat_r_q;
        unique case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                tmo_d   = '0;
                if (req_any) begin
                    state_d = ST_ACCESS;
                    grant_d = {{(NR_MASTERS-1){1'b0}}, 1'b1} << win_idx;
                    idx_d   = win_idx;
                    ptr_d   = win_next;
                end
            end
            ST_ACCESS: begin
                // A master walking away wins over any same-cycle slave answer.
                if (!sel_cyc) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    tmo_d   = '0;
                end else if (s_any) begin
                    state_d = ST_RESP;
                    dat_r_d = bus.s_dat_r;
                    err_d   = bus.s_err;
                    rty_d   = !bus.s_err && bus.s_rty;
                    ack_d   = !bus.s_err && !bus.s_rty && bus.s_ack;
                    tmo_d   = '0;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d = ST_RESP;
                    dat_r_d = '0;
                    err_d   = 1'b1;
                    rty_d   = 1'b0;
                    ack_d   = 1'b0;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                grant_d = '0;
                ack_d   = 1'b0;
                err_d   = 1'b0;
                rty_d   = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                tmo_d   = '0;
            end
        endcase
    end

    // grant_q is one-hot while a master is served, so it doubles as the
    // per-master response mask.
    always_comb begin
        bus.m_ack     = '0;
        bus.m_err     = '0;
        bus.m_rty     = '0;
        bus.s_adr     = '0;
        bus.s_dat_w   = '0;
        bus.s_we      = 1'b0;
        bus.m_dat_r   = dat_r_q;
        bus.grant     = grant_q;
        bus.dbg_state = state_q;
        if (state_q == ST_ACCESS) begin
            bus.s_adr   = sel_adr;
            bus.s_dat_w = sel_dat;
            bus.s_we    = sel_we;
        end
        if (state_q == ST_RESP) begin
            bus.m_ack = ack_q ? grant_q : '0;
            bus.m_err = err_q ? grant_q : '0;
            bus.m_rty = rty_q ? grant_q : '0;
        end
    end

    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(grant_q));
    a_flag_onehot:  assert property (@(posedge clk) disable iff (!rst) $onehot0({ack_q, err_q, rty_q}));
endmodule
